// File: rtl/approx_mac_pkg.sv
// rtl/approx_mac_pkg.sv - shared types, widths and saturating add for the product accumulator
package approx_mac_pkg;

    localparam int PROD_W    = 16;
    localparam int MAX_ACC_W = 64;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    // Unsigned add of two acc_w-bit values carried in MAX_ACC_W-bit containers.
    // Bit MAX_ACC_W of the result is the overflow flag; the low bits hold the
    // sum clamped to 2^acc_w - 1 when the true sum does not fit.
    function automatic logic [MAX_ACC_W:0] sat_add(
        input logic [MAX_ACC_W-1:0] a,
        input logic [MAX_ACC_W-1:0] b,
        input int unsigned          acc_w
    );
        logic [MAX_ACC_W:0] full;
        logic [MAX_ACC_W:0] limit;
        full  = {1'b0, a} + {1'b0, b};
        limit = ({{MAX_ACC_W{1'b0}}, 1'b1} << acc_w) - {{MAX_ACC_W{1'b0}}, 1'b1};
        if (full > limit) begin
            return {1'b1, limit[MAX_ACC_W-1:0]};
        end
        return {1'b0, full[MAX_ACC_W-1:0]};
    endfunction

endpackage

// File: rtl/approx_prod_accumulator_if.sv
// rtl/approx_prod_accumulator_if.sv - product-in / result-out handshake bundle
interface approx_prod_accumulator_if #(
    parameter int ACC_W   = 24,
    parameter int TERMS_W = 9
);
    import approx_mac_pkg::*;

    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod;
    logic              prod_last;
    logic              acc_valid;
    logic              acc_ready;
    logic [ACC_W-1:0]  acc_sum;
    logic [TERMS_W-1:0] acc_terms;
    logic              acc_sat;
    logic              acc_forced;

    // Upstream multiplier / downstream consumer side
    modport master (
        output prod_valid, prod, prod_last, acc_ready,
        input  prod_ready, acc_valid, acc_sum, acc_terms, acc_sat, acc_forced
    );

    // Accumulator side
    modport slave (
        input  prod_valid, prod, prod_last, acc_ready,
        output prod_ready, acc_valid, acc_sum, acc_terms, acc_sat, acc_forced
    );

endinterface

// File: rtl/sat_accum_reg.sv
// rtl/sat_accum_reg.sv - running sum register with saturating adder and sticky saturation flag
module sat_accum_reg
    import approx_mac_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              beat,
    input  logic              clear,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum_next,
    output logic              sat_next
);

    logic [ACC_W-1:0]   sum_q;
    logic               sat_q;
    logic [MAX_ACC_W:0] add_res;
    logic               unused_hi;

    // Sum including the current beat; the closing beat's value leaves through sum_next
    always_comb begin
        add_res   = sat_add(MAX_ACC_W'(sum_q), MAX_ACC_W'(prod), ACC_W);
        sum_next  = add_res[ACC_W-1:0];
        sat_next  = sat_q | add_res[MAX_ACC_W];
        unused_hi = ^(add_res >> ACC_W);
    end

    // Advance on every accepted beat; a closing beat restarts the window from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            sat_q <= 1'b0;
        end else if (beat) begin
            if (clear) begin
                sum_q <= '0;
                sat_q <= 1'b0;
            end else begin
                sum_q <= sum_next;
                sat_q <= sat_next;
            end
        end
    end

endmodule

// File: rtl/approx_prod_accumulator.sv
// rtl/approx_prod_accumulator.sv - windowed saturating sum of approximate-multiplier products
module approx_prod_accumulator
    import approx_mac_pkg::*;
#(
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    approx_prod_accumulator_if.slave  bus
);

    localparam int TERMS_W = $clog2(MAX_TERMS + 1);

    acc_state_e         state;
    logic [TERMS_W-1:0] terms_q;
    logic [TERMS_W-1:0] terms_next;
    logic               accept;
    logic               limit_hit;
    logic               close;
    logic [ACC_W-1:0]   sum_next;
    logic               sat_next;

    logic               acc_valid_q;
    logic [ACC_W-1:0]   acc_sum_q;
    logic [TERMS_W-1:0] acc_terms_q;
    logic               acc_sat_q;
    logic               acc_forced_q;

    // Beat acceptance and window-close decode
    always_comb begin
        accept     = bus.prod_valid && (state == ACCUM);
        terms_next = terms_q + TERMS_W'(1);
        limit_hit  = (terms_next == TERMS_W'(MAX_TERMS));
        close      = accept && (bus.prod_last || limit_hit);
    end

    sat_accum_reg #(
        .ACC_W (ACC_W)
    ) u_sat_accum_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .beat     (accept),
        .clear    (close),
        .prod     (bus.prod),
        .sum_next (sum_next),
        .sat_next (sat_next)
    );

    // Window FSM: count terms, capture the result on close, hold it until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACCUM;
            terms_q      <= '0;
            acc_valid_q  <= 1'b0;
            acc_sum_q    <= '0;
            acc_terms_q  <= '0;
            acc_sat_q    <= 1'b0;
            acc_forced_q <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (close) begin
                            acc_valid_q  <= 1'b1;
                            acc_sum_q    <= sum_next;
                            acc_terms_q  <= terms_next;
                            acc_sat_q    <= sat_next;
                            acc_forced_q <= limit_hit && !bus.prod_last;
                            terms_q      <= '0;
                            state        <= HOLD;
                        end else begin
                            terms_q <= terms_next;
                        end
                    end
                end
                HOLD: begin
                    if (bus.acc_ready) begin
                        acc_valid_q <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.prod_ready = (state == ACCUM);
    assign bus.acc_valid  = acc_valid_q;
    assign bus.acc_sum    = acc_sum_q;
    assign bus.acc_terms  = acc_terms_q;
    assign bus.acc_sat    = acc_sat_q;
    assign bus.acc_forced = acc_forced_q;

endmodule
